// File: rtl/l1_burst_responder_pkg.sv
// ----------------------------------------------------------------------------
// taiga_types
// Shared types for the L1 burst responder: FSM state encoding, the request
// fields latched at accept time, and the burst base-address helper.
// ----------------------------------------------------------------------------
package taiga_types;

    // Width of the request size field (beats - 1). The latched-request struct
    // is sized from this, so the responder's SIZE_W must match it.
    localparam int L1_SIZE_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } l1_state_t;

    typedef struct packed {
        logic [31:0]          addr;
        logic                 rnw;
        logic [3:0]           be;
        logic [31:0]          data;
        logic [L1_SIZE_W-1:0] size;
    } l1_req_t;

    // Line-aligned base of a read burst. Because beats = size+1 is a power of
    // two, the byte offset inside the line is exactly {size, 2'b11}, so
    // masking with that clears bits [$clog2(size+1)+1:0] without a log2.
    function automatic logic [31:0] burst_base(input logic [31:0]          addr,
                                               input logic [L1_SIZE_W-1:0] size);
        logic [31:0] mask;
        mask = {{(32-L1_SIZE_W-2){1'b0}}, size, 2'b11};
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/l1_burst_responder_if.sv
// ----------------------------------------------------------------------------
// l1_burst_responder_if
// Bundles the L1 arbiter request/return signals and the backend memory port.
//   slave  : responder view (takes L1 requests, drives the backend port)
//   master : environment view (arbiter side plus backend memory model)
// ----------------------------------------------------------------------------
interface l1_burst_responder_if #(
    parameter int SIZE_W = 5
);
    // L1 arbiter side
    logic              l1_request;
    logic [31:0]       l1_addr;
    logic              l1_rnw;
    logic [3:0]        l1_be;
    logic [31:0]       l1_data;
    logic [SIZE_W-1:0] l1_size;
    logic              l1_ack;
    logic              l1_data_valid;
    logic [31:0]       l1_data_out;

    // Backend memory side
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  l1_request, l1_addr, l1_rnw, l1_be, l1_data, l1_size,
        output l1_ack, l1_data_valid, l1_data_out,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output l1_request, l1_addr, l1_rnw, l1_be, l1_data, l1_size,
        input  l1_ack, l1_data_valid, l1_data_out,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/l1_burst_responder_outstanding_counter.sv
// ----------------------------------------------------------------------------
// l1_outstanding_counter
// Tracks backend reads issued and returned for the current read burst.
//   clk, rst      : clock, synchronous active-high reset
//   i_clear       : new request accepted, restart both counts
//   i_active      : responder is in the READ state
//   i_issue       : backend accepted a read this cycle (mem_req & mem_gnt)
//   i_rvalid      : backend returned read data this cycle
//   i_size        : latched burst size (beats - 1)
//   o_issue_cnt   : index of the next beat to issue
//   o_can_issue   : more beats to issue and below the outstanding limit
//   o_ret_accept  : this cycle's rvalid belongs to the burst
//   o_burst_done  : this cycle's accepted return is the final beat
// ----------------------------------------------------------------------------
module l1_outstanding_counter #(
    parameter int SIZE_W          = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_active,
    input  logic              i_issue,
    input  logic              i_rvalid,
    input  logic [SIZE_W-1:0] i_size,
    output logic [SIZE_W:0]   o_issue_cnt,
    output logic              o_can_issue,
    output logic              o_ret_accept,
    output logic              o_burst_done
);
    localparam logic [SIZE_W:0] MAX_OUT = (SIZE_W+1)'(MAX_OUTSTANDING);
    localparam logic [SIZE_W:0] ONE     = (SIZE_W+1)'(1);

    logic [SIZE_W:0] r_issue_cnt;
    logic [SIZE_W:0] r_return_cnt;
    logic [SIZE_W:0] w_outstanding;
    logic [SIZE_W:0] w_size_ext;

    assign w_size_ext    = {1'b0, i_size};
    assign w_outstanding = r_issue_cnt - r_return_cnt;

    assign o_issue_cnt  = r_issue_cnt;
    assign o_can_issue  = i_active && (r_issue_cnt <= w_size_ext) && (w_outstanding < MAX_OUT);
    // A return with nothing outstanding is stale (e.g. from before a reset)
    // and is dropped here rather than being counted as a beat.
    assign o_ret_accept = i_active && i_rvalid && (w_outstanding != '0);
    assign o_burst_done = o_ret_accept && (r_return_cnt == w_size_ext);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_issue_cnt  <= '0;
            r_return_cnt <= '0;
        end else begin
            if (i_active && i_issue) begin
                r_issue_cnt <= r_issue_cnt + ONE;
            end
            if (o_ret_accept) begin
                r_return_cnt <= r_return_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/l1_burst_responder.sv
// ----------------------------------------------------------------------------
// l1_burst_responder
// Memory-side responder for the L1 arbiter. Accepts one request at a time,
// turns line reads into pipelined single-word backend reads returned as a
// line-aligned burst (word 0 first), and turns writes into one byte-enabled
// backend store with no return beat.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : l1_burst_responder_if.slave (L1 request/return + backend port)
// Parameters: SIZE_W (size field width, must equal L1_SIZE_W),
//             MAX_OUTSTANDING (backend reads in flight, 1..15).
//
// state | meaning
// IDLE  | waiting for l1_request; ack is combinational here
// READ  | issuing backend reads and forwarding returns as beats
// WRITE | holding the backend store until mem_gnt
// ----------------------------------------------------------------------------
module l1_burst_responder
    import taiga_types::*;
#(
    parameter int SIZE_W          = L1_SIZE_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    l1_burst_responder_if.slave bus
);
    l1_state_t   r_state;
    l1_req_t     r_req;
    logic        r_data_valid;
    logic [31:0] r_data_out;

    logic            w_ack;
    logic            w_read_active;
    logic            w_can_issue;
    logic            w_ret_accept;
    logic            w_burst_done;
    logic [SIZE_W:0] w_issue_cnt;
    logic [31:0]     w_base;
    logic [SIZE_W:0] w_req_size_ext;
    logic [SIZE_W:0] w_req_beats;

    assign w_ack         = bus.l1_request && (r_state == IDLE);
    assign w_read_active = (r_state == READ);
    assign w_base        = burst_base(r_req.addr, r_req.size);

    l1_outstanding_counter #(
        .SIZE_W          (SIZE_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_ack),
        .i_active     (w_read_active),
        .i_issue      (bus.mem_req && bus.mem_gnt),
        .i_rvalid     (bus.mem_rvalid),
        .i_size       (r_req.size),
        .o_issue_cnt  (w_issue_cnt),
        .o_can_issue  (w_can_issue),
        .o_ret_accept (w_ret_accept),
        .o_burst_done (w_burst_done)
    );

    assign bus.l1_ack        = w_ack;
    assign bus.l1_data_valid = r_data_valid;
    assign bus.l1_data_out   = r_data_out;

    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        case (r_state)
            READ: begin
                bus.mem_req  = w_can_issue;
                bus.mem_addr = w_base + {{(32-SIZE_W-3){1'b0}}, w_issue_cnt, 2'b00};
                bus.mem_be   = 4'hF;
            end
            WRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {r_req.addr[31:2], 2'b00};
                bus.mem_be    = r_req.be;
                bus.mem_wdata = r_req.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            // Return side never stalls: every accepted rvalid becomes a beat
            // next cycle, and the data bus is zero otherwise so initiators
            // can OR-combine responders.
            r_data_valid <= w_ret_accept;
            r_data_out   <= w_ret_accept ? bus.mem_rdata : '0;
            case (r_state)
                IDLE: begin
                    if (w_ack) begin
                        r_req <= '{addr: bus.l1_addr,
                                   rnw:  bus.l1_rnw,
                                   be:   bus.l1_be,
                                   data: bus.l1_data,
                                   size: bus.l1_size};
                        r_state <= bus.l1_rnw ? READ : WRITE;
                    end
                end
                READ: begin
                    // Leaving on the last return lets the next ack land in
                    // the same cycle the final beat is presented.
                    if (w_burst_done) begin
                        r_state <= IDLE;
                    end
                end
                WRITE: begin
                    if (bus.mem_gnt) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_req_size_ext = {1'b0, bus.l1_size};
    assign w_req_beats    = w_req_size_ext + (SIZE_W+1)'(1);

    a_ack_has_request: assert property (@(posedge clk) disable iff (rst)
        bus.l1_ack |-> bus.l1_request);

    a_request_drops_after_ack: assert property (@(posedge clk) disable iff (rst)
        bus.l1_ack |=> !bus.l1_request);

    a_read_size_pow2: assert property (@(posedge clk) disable iff (rst)
        (bus.l1_ack && bus.l1_rnw) |-> ((w_req_beats & w_req_size_ext) == '0));

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rvalid |-> w_ret_accept);

endmodule

// File: tb/tb_l1_burst_responder.sv
module tb_l1_burst_responder;
    localparam int SIZE_W  = 5;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_burst_responder_if #(.SIZE_W(SIZE_W)) bus ();

    l1_burst_responder #(
        .SIZE_W          (SIZE_W),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    mem_exp_t    exp_mem[$];
    logic [31:0] exp_beat[$];
    int unsigned beat_cyc[$];
    int unsigned hs_cyc[$];
    pend_t       pend[$];
    int          lat     = 1;
    int          out_cnt = 0;
    int          max_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int unsigned at(input int unsigned q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd);
        exp_mem.push_back('{a, we, be, wd});
    endtask

    // Backend memory model: data word = 0xD000_0000 | word address.
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hD000_0000 | pend[0].addr;
                void'(pend.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
            end
            @(negedge clk);
            if (bus.mem_req && bus.mem_gnt && !bus.mem_we)
                pend.push_back('{bus.mem_addr, cyc + lat});
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        mem_exp_t e;
        forever begin
            @(negedge clk);
            if (bus.l1_data_valid) begin
                beat_cyc.push_back(cyc);
                if (exp_beat.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got beat 0x%08h at cycle %0d, expected none",
                             bus.l1_data_out, cyc);
                end else begin
                    check("beat_data", bus.l1_data_out, exp_beat.pop_front());
                end
            end else begin
                check("data_out_zero_when_idle", bus.l1_data_out, 32'h0);
            end

            if (bus.mem_req && bus.mem_gnt) begin
                hs_cyc.push_back(cyc);
                if (exp_mem.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got mem addr 0x%08h we %0b, expected none",
                             bus.mem_addr, bus.mem_we);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_addr",  bus.mem_addr,        e.addr);
                    check("mem_we",    32'(bus.mem_we),     32'(e.we));
                    check("mem_be",    32'(bus.mem_be),     32'(e.be));
                    check("mem_wdata", bus.mem_wdata,       e.wdata);
                end
            end

            if (rst) begin
                out_cnt = 0;
            end else begin
                if (bus.mem_req && bus.mem_gnt && !bus.mem_we) out_cnt++;
                if (bus.mem_rvalid) out_cnt--;
                if (out_cnt > max_out) max_out = out_cnt;
                if (bus.mem_req && bus.mem_gnt && !bus.mem_we)
                    check("outstanding_limit", 32'(out_cnt <= MAX_OUT), 32'd1);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic rnw, input logic [3:0] be,
                         input logic [31:0] d, input logic [SIZE_W-1:0] sz,
                         output int unsigned ack_c);
        bus.l1_request = 1'b1;
        bus.l1_addr    = a;
        bus.l1_rnw     = rnw;
        bus.l1_be      = be;
        bus.l1_data    = d;
        bus.l1_size    = sz;
        ack_c = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.l1_ack) begin
                ack_c = cyc;
                break;
            end
            tick();
        end
        if (ack_c == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack for addr 0x%08h, expected ack within 50 cycles", a);
        end
        tick();
        bus.l1_request = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int i;
        i = 0;
        while (beat_cyc.size() < n && i < budget) begin
            tick();
            i++;
        end
        repeat (4) tick();
        check("beat_count", 32'(beat_cyc.size()), 32'(n));
    endtask

    task automatic clear_logs();
        beat_cyc.delete();
        hs_cyc.delete();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish by 100000 time units, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int unsigned a;
        int unsigned a2;
        rst            = 1'b1;
        bus.l1_request = 1'b0;
        bus.l1_addr    = '0;
        bus.l1_rnw     = 1'b0;
        bus.l1_be      = '0;
        bus.l1_data    = '0;
        bus.l1_size    = '0;
        bus.mem_gnt    = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ack",        32'(bus.l1_ack),        32'd0);
        check("rst_data_valid", 32'(bus.l1_data_valid), 32'd0);
        check("rst_data_out",   bus.l1_data_out,        32'h0);
        check("rst_mem_req",    32'(bus.mem_req),       32'd0);
        check("rst_mem_we",     32'(bus.mem_we),        32'd0);
        tick();

        // Line read at 0x1234 size 3, then a new request in the final beat cycle
        clear_logs();
        push_mem(32'h0000_1230, 1'b0, 4'hF, 32'h0);
        push_mem(32'h0000_1234, 1'b0, 4'hF, 32'h0);
        push_mem(32'h0000_1238, 1'b0, 4'hF, 32'h0);
        push_mem(32'h0000_123C, 1'b0, 4'hF, 32'h0);
        exp_beat.push_back(32'hD000_1230);
        exp_beat.push_back(32'hD000_1234);
        exp_beat.push_back(32'hD000_1238);
        exp_beat.push_back(32'hD000_123C);
        push_mem(32'h0000_5000, 1'b0, 4'hF, 32'h0);
        push_mem(32'h0000_5004, 1'b0, 4'hF, 32'h0);
        exp_beat.push_back(32'hD000_5000);
        exp_beat.push_back(32'hD000_5004);
        issue(32'h0000_1234, 1'b1, 4'hF, 32'h0, 5'd3, a);
        while (cyc < a + 6) tick();
        issue(32'h0000_5000, 1'b1, 4'hF, 32'h0, 5'd1, a2);
        check("t4_ack_in_last_beat_cycle", 32'(a2), 32'(a + 6));
        wait_beats(6, 40);
        check("t1_beat0_cycle", at(beat_cyc, 0), 32'(a + 3));
        check("t1_beat1_cycle", at(beat_cyc, 1), 32'(a + 4));
        check("t1_beat2_cycle", at(beat_cyc, 2), 32'(a + 5));
        check("t1_beat3_cycle", at(beat_cyc, 3), 32'(a + 6));
        check("t1_issue0_cycle", at(hs_cyc, 0), 32'(a + 1));
        check("t1_issue3_cycle", at(hs_cyc, 3), 32'(a + 4));
        check("t4_first_issue_cycle", at(hs_cyc, 4), 32'(a + 7));
        check("t4_beat0_cycle", at(beat_cyc, 4), 32'(a + 9));
        check("t4_beat1_cycle", at(beat_cyc, 5), 32'(a + 10));
        @(negedge clk);
        check("t1_idle_mem_req", 32'(bus.mem_req), 32'd0);
        tick();

        // Latency-6 backend, size 7 at 0x4010: line base 0x4000, <=4 in flight
        clear_logs();
        lat     = 6;
        max_out = 0;
        for (int k = 0; k < 8; k++) begin
            push_mem(32'h0000_4000 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
            exp_beat.push_back(32'hD000_4000 + 32'(4 * k));
        end
        issue(32'h0000_4010, 1'b1, 4'hF, 32'h0, 5'd7, a);
        wait_beats(8, 200);
        check("t2_max_outstanding", 32'(max_out), 32'd4);
        check("t2_first_issue_cycle", at(hs_cyc, 0), 32'(a + 1));
        check("t2_first_beat_cycle",  at(beat_cyc, 0), 32'(a + 8));
        lat = 1;
        tick();

        // Reset after 2 of 4 beats while the backend still returns 2 more
        clear_logs();
        push_mem(32'h0000_6000, 1'b0, 4'hF, 32'h0);
        push_mem(32'h0000_6004, 1'b0, 4'hF, 32'h0);
        push_mem(32'h0000_6008, 1'b0, 4'hF, 32'h0);
        push_mem(32'h0000_600C, 1'b0, 4'hF, 32'h0);
        exp_beat.push_back(32'hD000_6000);
        exp_beat.push_back(32'hD000_6004);
        issue(32'h0000_6000, 1'b1, 4'hF, 32'h0, 5'd3, a);
        while (cyc < a + 4) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t5_ack_after_rst",        32'(bus.l1_ack),        32'd0);
        check("t5_mem_req_after_rst",    32'(bus.mem_req),       32'd0);
        check("t5_data_valid_after_rst", 32'(bus.l1_data_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_idle_mem_req",    32'(bus.mem_req),       32'd0);
            check("t5_idle_data_valid", 32'(bus.l1_data_valid), 32'd0);
            tick();
        end
        check("t5_beats_before_rst", 32'(beat_cyc.size()), 32'd2);
        check("t5_issued_reads",     32'(hs_cyc.size()),   32'd4);

        // Write at 0x2002 with grant held off, then size-0 read at 0x3007
        clear_logs();
        bus.mem_gnt = 1'b0;
        push_mem(32'h0000_2000, 1'b1, 4'b1100, 32'hDEAD_BEEF);
        push_mem(32'h0000_3004, 1'b0, 4'hF, 32'h0);
        exp_beat.push_back(32'hD000_3004);
        issue(32'h0000_2002, 1'b0, 4'b1100, 32'hDEAD_BEEF, 5'd0, a);
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) bus.mem_gnt = 1'b1;
            @(negedge clk);
            check("t3_mem_req_held", 32'(bus.mem_req),  32'd1);
            check("t3_mem_we_held",  32'(bus.mem_we),   32'd1);
            check("t3_mem_addr",     bus.mem_addr,      32'h0000_2000);
            tick();
        end
        check("t3_no_beat", 32'(beat_cyc.size()), 32'd0);
        issue(32'h0000_3007, 1'b1, 4'hF, 32'h0, 5'd0, a2);
        check("t3_next_ack_after_gnt", 32'(a2), 32'(a + 4));
        wait_beats(1, 20);
        check("t3_write_gnt_cycle",  at(hs_cyc, 0),   32'(a + 3));
        check("t6_issue_cycle",      at(hs_cyc, 1),   32'(a2 + 1));
        check("t6_issue_count",      32'(hs_cyc.size()), 32'd2);
        check("t6_beat_cycle",       at(beat_cyc, 0), 32'(a2 + 3));

        check("sb_mem_drained",  32'(exp_mem.size()),  32'd0);
        check("sb_beat_drained", 32'(exp_beat.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
